nwcc_pulse_gen: RTL and testbench

Synthetic neutron pulse-train source for the coincidence-counter datapath. It produces single-cycle pulses on a 1 MHz clock that feed the counter's pulse input: random "accidental" primaries come from an LFSR, and every Nth primary spawns a correlated follower after a programmable delay. The block is used as on-chip stimulus and for self-test. It keeps its own emitted, paired and dropped tallies so that R+A and A results can be checked against known truth.

---
 rtl/nwcc_pkg.sv | 31 +++
 rtl/nwcc_pulse_gen_if.sv | 29 ++
 rtl/nwcc_ts_fifo.sv | 55 +++++
 rtl/nwcc_pulse_gen.sv | 120 ++++++++++++
 tb/tb_nwcc_pulse_gen.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/nwcc_pkg.sv
// nwcc_pkg: shared constants, types and helpers for the synthetic pulse source.
//   LFSR taps and default seed, minimum follower spacing, default widths,
//   pulse-source enum, LFSR step and delay clamp helpers.
package nwcc_pkg;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    localparam int unsigned MIN_FOLLOW_DELAY  = 2;

    localparam int unsigned DEF_DATA_BITS  = 24;
    localparam int unsigned DEF_TS_BITS    = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 8;

    // What drives o_pulse in the next cycle.
    typedef enum logic [1:0] {
        SrcNone,
        SrcPrimary,
        SrcFollower
    } pulse_src_e;

    // One step of a right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Spacing of 0 or 1 would merge follower and primary; force a low cycle between.
    function automatic logic [9:0] clamp_delay(input logic [9:0] d);
        return (d < 10'(MIN_FOLLOW_DELAY)) ? 10'(MIN_FOLLOW_DELAY) : d;
    endfunction

endpackage

// File: rtl/nwcc_pulse_gen_if.sv
// nwcc_pulse_gen_if: configuration inputs and pulse/tally outputs of nwcc_pulse_gen.
//   master: stimulus side (drives i_*, reads o_*)
//   slave : pulse generator (reads i_*, drives o_*)
interface nwcc_pulse_gen_if #(
    parameter int unsigned DATA_BITS = nwcc_pkg::DEF_DATA_BITS
);
    logic                 i_enable;
    logic [15:0]          i_rate_thresh;
    logic [7:0]           i_pair_every;
    logic [9:0]           i_follow_delay;
    logic [15:0]          i_seed;
    logic                 i_load_seed;
    logic                 o_pulse;
    logic [DATA_BITS-1:0] o_total_emitted;
    logic [DATA_BITS-1:0] o_pairs_emitted;
    logic [DATA_BITS-1:0] o_dropped;
    logic                 o_busy;

    modport master (
        output i_enable, i_rate_thresh, i_pair_every, i_follow_delay, i_seed, i_load_seed,
        input  o_pulse, o_total_emitted, o_pairs_emitted, o_dropped, o_busy
    );

    modport slave (
        input  i_enable, i_rate_thresh, i_pair_every, i_follow_delay, i_seed, i_load_seed,
        output o_pulse, o_total_emitted, o_pairs_emitted, o_dropped, o_busy
    );

endinterface

// File: rtl/nwcc_ts_fifo.sv
// nwcc_ts_fifo: synchronous FIFO of follower due timestamps.
//   clk, reset (async, active-high)
//   push_i/data_i : enqueue (ignored when full)
//   pop_i         : dequeue (ignored when empty)
//   head_o        : oldest entry, full_o/empty_o : occupancy flags
module nwcc_ts_fifo #(
    parameter int unsigned TS_BITS    = nwcc_pkg::DEF_TS_BITS,
    parameter int unsigned FIFO_DEPTH = nwcc_pkg::DEF_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic [TS_BITS-1:0] data_i,
    input  logic               pop_i,
    output logic [TS_BITS-1:0] head_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [TS_BITS-1:0] mem_q [FIFO_DEPTH];
    // Pointers carry one wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/nwcc_pulse_gen.sv
// nwcc_pulse_gen: synthetic neutron pulse-train source.
//   clk   : 1 MHz clock
//   reset : async, active-high
//   bus   : nwcc_pulse_gen_if.slave -- rate/pairing/delay/seed controls in,
//           single-cycle o_pulse plus emitted/paired/dropped tallies and o_busy out.
// LFSR primaries; every Nth emitted primary queues a follower due D cycles later.
module nwcc_pulse_gen
    import nwcc_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned TS_BITS    = DEF_TS_BITS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input logic              clk,
    input logic              reset,
    nwcc_pulse_gen_if.slave  bus
);
    logic [15:0]          lfsr_q, lfsr_d;
    logic [TS_BITS-1:0]   now_q, now_d;
    logic [7:0]           pair_cnt_q, pair_cnt_d;
    logic [9:0]           delay_q, delay_d;
    logic                 pulse_q, pulse_d;
    logic [DATA_BITS-1:0] total_q, total_d;
    logic [DATA_BITS-1:0] pairs_q, pairs_d;
    logic [DATA_BITS-1:0] dropped_q, dropped_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [TS_BITS-1:0] fifo_head, due_ts, ts_diff;
    logic               cand, head_due, drop;
    pulse_src_e         src;

    nwcc_ts_fifo #(
        .TS_BITS    (TS_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (due_ts),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cand   = bus.i_enable && (lfsr_q < bus.i_rate_thresh);
    assign due_ts = now_q + TS_BITS'(delay_q);
    // Wrap-safe "now >= head": difference interpreted as signed.
    assign ts_diff  = now_q - fifo_head;
    assign head_due = !fifo_empty && !ts_diff[TS_BITS-1];

    always_comb begin
        src        = SrcNone;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        drop       = 1'b0;
        pair_cnt_d = pair_cnt_q;

        if (pulse_q) begin
            // Dead time: primaries are lost, a due follower just waits a cycle.
            drop = cand;
        end else if (head_due) begin
            src      = SrcFollower;
            fifo_pop = 1'b1;
            drop     = cand;
        end else if (cand) begin
            src = SrcPrimary;
            if (bus.i_pair_every != 8'd0 && pair_cnt_q == bus.i_pair_every - 8'd1) begin
                pair_cnt_d = 8'd0;
                if (fifo_full) drop = 1'b1;
                else           fifo_push = 1'b1;
            end else begin
                pair_cnt_d = pair_cnt_q + 8'd1;
            end
        end

        pulse_d   = (src != SrcNone);
        total_d   = total_q + (pulse_d ? DATA_BITS'(1) : DATA_BITS'(0));
        pairs_d   = pairs_q + ((src == SrcFollower) ? DATA_BITS'(1) : DATA_BITS'(0));
        dropped_d = dropped_q + (drop ? DATA_BITS'(1) : DATA_BITS'(0));

        now_d = now_q + TS_BITS'(1);
        if (bus.i_load_seed) begin
            lfsr_d = (bus.i_seed == 16'h0000) ? LFSR_DEFAULT_SEED : bus.i_seed;
        end else begin
            lfsr_d = lfsr_next(lfsr_q);
        end
        // Freezing D while entries are queued keeps the FIFO sorted by due time.
        delay_d = fifo_empty ? clamp_delay(bus.i_follow_delay) : delay_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q     <= LFSR_DEFAULT_SEED;
            now_q      <= '0;
            pair_cnt_q <= '0;
            delay_q    <= 10'(MIN_FOLLOW_DELAY);
            pulse_q    <= 1'b0;
            total_q    <= '0;
            pairs_q    <= '0;
            dropped_q  <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            now_q      <= now_d;
            pair_cnt_q <= pair_cnt_d;
            delay_q    <= delay_d;
            pulse_q    <= pulse_d;
            total_q    <= total_d;
            pairs_q    <= pairs_d;
            dropped_q  <= dropped_d;
        end
    end

    assign bus.o_pulse         = pulse_q;
    assign bus.o_total_emitted = total_q;
    assign bus.o_pairs_emitted = pairs_q;
    assign bus.o_dropped       = dropped_q;
    assign bus.o_busy          = !fifo_empty;

endmodule

// File: tb/tb_nwcc_pulse_gen.sv
// tb_nwcc_pulse_gen: directed self-checking bench for nwcc_pulse_gen.
// Holding i_load_seed freezes the LFSR so i_rate_thresh alone decides each primary.
module tb_nwcc_pulse_gen;

    logic clk = 1'b0;
    logic reset;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int cyc = 0;
    int pulse_times[$];

    nwcc_pulse_gen_if #(.DATA_BITS(24)) bus ();

    nwcc_pulse_gen #(
        .DATA_BITS  (24),
        .TS_BITS    (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.o_pulse === 1'b1) pulse_times.push_back(cyc);

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int tot, input int prs, input int drp,
                           input int busy);
        check({tag, ".total"},   longint'(bus.o_total_emitted), longint'(tot));
        check({tag, ".pairs"},   longint'(bus.o_pairs_emitted), longint'(prs));
        check({tag, ".dropped"}, longint'(bus.o_dropped),       longint'(drp));
        check({tag, ".busy"},    longint'(bus.o_busy),          longint'(busy));
    endtask

    // One primary candidate decision, then `gap` quiet decisions.
    task automatic fire(input int gap);
        bus.i_rate_thresh = 16'hFFFF;
        step(1);
        bus.i_rate_thresh = 16'h0000;
        step(gap);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        pulse_times.delete();
    endtask

    initial begin
        reset              = 1'b1;
        bus.i_enable       = 1'b1;
        bus.i_rate_thresh  = 16'h0000;
        bus.i_pair_every   = 8'd1;
        bus.i_follow_delay = 10'd100;
        bus.i_seed         = 16'h0001;
        bus.i_load_seed    = 1'b1;
        #1;
        check("reset.pulse", longint'(bus.o_pulse), 0);
        chk_cnt("reset", 0, 0, 0, 0);

        // Quiet: threshold 0 never fires.
        step(2);
        reset = 1'b0;
        pulse_times.delete();
        step(1000);
        chk_cnt("quiet", 0, 0, 0, 0);
        check("quiet.npulses", pulse_times.size(), 0);

        // Single primary spawns one follower exactly 100 cycles later.
        bus.i_seed = 16'h1234;
        do_reset();
        fire(110);
        check("single.npulses", pulse_times.size(), 2);
        check("single.spacing", pulse_times[1] - pulse_times[0], 100);
        chk_cnt("single", 2, 1, 0, 0);

        // Continuous candidates: dead time halves the output.
        do_reset();
        bus.i_pair_every  = 8'd0;
        bus.i_rate_thresh = 16'hFFFF;
        step(200);
        bus.i_rate_thresh = 16'h0000;
        step(2);
        chk_cnt("alt", 100, 0, 100, 0);
        check("alt.span", pulse_times[99] - pulse_times[0], 198);

        // Nine followers queued into an 8-deep FIFO.
        do_reset();
        bus.i_pair_every   = 8'd1;
        bus.i_follow_delay = 10'd1000;
        step(2);
        for (int i = 0; i < 9; i++) fire(2);
        chk_cnt("full", 9, 0, 1, 1);
        for (int i = 0; i < 1200 && bus.o_busy; i++) step(1);
        check("full.drained", longint'(bus.o_busy), 0);
        check("full.lastpulse", longint'(bus.o_pulse), 1);
        chk_cnt("full.end", 17, 8, 1, 0);
        step(5);
        check("full.npulses", pulse_times.size(), 17);
        check("full.first_follow", pulse_times[9] - pulse_times[0], 1000);
        check("full.last_follow", pulse_times[16] - pulse_times[7], 1000);

        // Follower due while o_pulse is high: deferred one cycle, no drop.
        do_reset();
        bus.i_pair_every   = 8'd2;
        bus.i_follow_delay = 10'd10;
        step(2);
        fire(3);
        fire(8);
        fire(20);
        check("defer.npulses", pulse_times.size(), 4);
        check("defer.p2", pulse_times[2] - pulse_times[1], 9);
        check("defer.follow", pulse_times[3] - pulse_times[1], 11);
        chk_cnt("defer", 4, 1, 0, 0);

        // Follower vs primary candidate: follower wins, primary dropped and not counted.
        do_reset();
        step(2);
        fire(3);
        fire(9);
        fire(5);
        fire(1);
        check("collide.nospawn", longint'(bus.o_busy), 0);
        step(20);
        check("collide.npulses", pulse_times.size(), 4);
        check("collide.follow", pulse_times[2] - pulse_times[1], 10);
        chk_cnt("collide", 4, 1, 1, 0);

        // Reset with followers pending wipes them.
        do_reset();
        bus.i_pair_every   = 8'd1;
        bus.i_follow_delay = 10'd100;
        step(2);
        for (int i = 0; i < 4; i++) fire(2);
        chk_cnt("prereset", 4, 0, 0, 1);
        reset = 1'b1;
        #1;
        chk_cnt("midreset", 0, 0, 0, 0);
        check("midreset.pulse", longint'(bus.o_pulse), 0);
        step(2);
        reset = 1'b0;
        pulse_times.delete();
        step(150);
        check("postreset.npulses", pulse_times.size(), 0);
        chk_cnt("postreset", 0, 0, 0, 0);

        // Free-running LFSR from seed 1: states < 0x100 in first 16 are
        // 0x0001, 0x00B4, 0x005A (dead time), 0x002D.
        bus.i_pair_every = 8'd0;
        bus.i_seed       = 16'h0001;
        step(1);
        pulse_times.delete();
        bus.i_load_seed   = 1'b0;
        bus.i_rate_thresh = 16'h0100;
        step(16);
        bus.i_rate_thresh = 16'h0000;
        step(2);
        chk_cnt("lfsr", 3, 0, 1, 0);
        check("lfsr.gap1", pulse_times[1] - pulse_times[0], 9);
        check("lfsr.gap2", pulse_times[2] - pulse_times[1], 2);

        // Seed 0 loads 0xACE1.
        bus.i_load_seed = 1'b1;
        bus.i_seed      = 16'h0000;
        step(1);
        bus.i_rate_thresh = 16'hACE1;
        step(1);
        bus.i_rate_thresh = 16'h0000;
        step(2);
        check("seed0.below", longint'(bus.o_total_emitted), 3);
        bus.i_rate_thresh = 16'hACE2;
        step(1);
        bus.i_rate_thresh = 16'h0000;
        step(2);
        check("seed0.above", longint'(bus.o_total_emitted), 4);

        // Reset LFSR value 0xACE1 drives the first decision after release.
        reset           = 1'b1;
        bus.i_load_seed = 1'b0;
        bus.i_rate_thresh = 16'hACE2;
        step(2);
        reset = 1'b0;
        check("rstlfsr.nopulse", longint'(bus.o_pulse), 0);
        step(1);
        bus.i_rate_thresh = 16'h0000;
        step(3);
        check("rstlfsr.total", longint'(bus.o_total_emitted), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
